fifo_rd_packer: RTL and testbench

// Read-domain consumer placed directly downstream of the async FIFO (read port side).

---
 rtl/fifo_rd_packer.sv | 102 ++++++++++
 tb/tb_fifo_rd_packer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: rate-limited consumer on the async FIFO read side.
// Pops words with a minimum spacing and packs pairs into {word1, word0} beats.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int READ_DELAY = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_rd,
  input  logic                    rst_rd,
  input  logic                    rempty,
  input  logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rinc,
  input  logic                    flush,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_WIDTH-1:0]    rd_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CAPT = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam int GAP_WIDTH = (READ_DELAY > 0) ? $clog2(READ_DELAY + 1) : 1;
  localparam logic [GAP_WIDTH-1:0] GAP_LOAD = GAP_WIDTH'(READ_DELAY);

  logic [1:0]            state;
  logic                  lane_idx;
  logic [DATA_WIDTH-1:0] lane0;
  logic [GAP_WIDTH-1:0]  gap_cnt;

  // Pop only from IDLE once the spacing gap has expired; flush and reset veto it.
  assign rinc = (state == IDLE) && !rempty && (gap_cnt == '0) && !flush && !rst_rd;

  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      gap_cnt <= '0;
    end else if (rinc) begin
      gap_cnt <= GAP_LOAD;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GAP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      rd_count <= '0;
    end else if (rinc) begin
      rd_count <= rd_count + CNT_WIDTH'(1);
    end
  end

  // A flush in CAPT drops the arriving word; it was already counted at the pop.
  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      state     <= IDLE;
      lane_idx  <= 1'b0;
      lane0     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      lane_idx  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rinc) begin
            state <= CAPT;
          end
        end
        CAPT: begin
          if (!lane_idx) begin
            lane0    <= rdata;
            lane_idx <= 1'b1;
            state    <= IDLE;
          end else begin
            out_data  <= {rdata, lane0};
            out_valid <= 1'b1;
            lane_idx  <= 1'b0;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A held beat must stay put until accepted, and the FIFO is never underflowed.
  assert property (@(posedge clk_rd) disable iff (rst_rd) rinc |-> !rempty);
  assert property (@(posedge clk_rd) disable iff (rst_rd)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO emulation plus a pairing reference model feeding
// a scoreboard queue, with a separate monitor checking every accepted beat.
module tb_fifo_rd_packer;

  localparam int RD      = 5;
  localparam int MIN_GAP = (RD + 1 > 2) ? RD + 1 : 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_rd    = 1'b1;
  logic        rempty    = 1'b1;
  logic        flush     = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  rdata     = 8'h00;
  logic        rinc;
  logic        out_valid;
  logic [15:0] out_data;
  logic [15:0] rd_count;

  fifo_rd_packer #(.DATA_WIDTH(8), .READ_DELAY(RD), .CNT_WIDTH(16)) dut (
    .clk_rd(clk), .rst_rd(rst_rd), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .rd_count(rd_count)
  );

  // Narrow-counter instance so the counter wrap is reachable in a short run.
  logic        rst_w = 1'b1;
  logic        rinc_w;
  logic        out_valid_w;
  logic [15:0] out_data_w;
  logic [3:0]  rd_count_w;

  fifo_rd_packer #(.DATA_WIDTH(8), .READ_DELAY(0), .CNT_WIDTH(4)) dut_w (
    .clk_rd(clk), .rst_rd(rst_w), .rempty(1'b0), .rdata(8'h5A), .rinc(rinc_w),
    .flush(1'b0), .out_data(out_data_w), .out_valid(out_valid_w),
    .out_ready(1'b1), .rd_count(rd_count_w)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  logic [7:0]  fifo_q[$];
  logic [7:0]  pending[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_cnt = 16'h0000;
  int          pops = 0;
  int          cyc = 0;
  int          last_pop = -1;
  int          pop_cyc[$];
  bit          check_en = 1'b0;

  // Environment: FIFO read port plus reference model (words pair up in pop order,
  // flush or reset throws away anything not yet accepted downstream).
  always begin
    logic [7:0] popped;
    bit         did_pop;
    @(negedge clk);
    cyc++;
    did_pop = 1'b0;
    popped  = 8'h00;
    if (check_en) begin
      check_output("rd_count", rd_count, exp_cnt);
      if (rinc) check_output("rinc_blocked", {rempty, flush, rst_rd}, 3'b000);
    end
    if (rst_rd) begin
      exp_cnt  = 16'h0000;
      pops     = 0;
      last_pop = -1;
      pending.delete();
      exp_q.delete();
      pop_cyc.delete();
    end else begin
      if (rinc) begin
        if (check_en && last_pop >= 0)
          check_output("pop_spacing", (cyc - last_pop) >= MIN_GAP, 1);
        last_pop = cyc;
        pop_cyc.push_back(cyc);
        exp_cnt++;
        pops++;
        if (fifo_q.size() > 0) popped = fifo_q.pop_front();
        did_pop = 1'b1;
        pending.push_back(popped);
        if (pending.size() == 2) begin
          exp_q.push_back({pending[1], pending[0]});
          pending.delete();
        end
      end
      if (flush) begin
        pending.delete();
        exp_q.delete();
      end
    end
    @(posedge clk);
    #1;
    if (did_pop) rdata = popped;
    rempty = (fifo_q.size() == 0);
  end

  int          beats = 0;
  int          valid_cycles = 0;
  bit          held_prev = 1'b0;
  logic [15:0] held_data = 16'h0000;

  // Monitor: every accepted beat is popped from the scoreboard and compared.
  always begin
    @(negedge clk);
    if (check_en && !rst_rd && !flush) begin
      if (held_prev) begin
        check_output("hold_valid", out_valid, 1);
        check_output("hold_data", out_data, held_data);
      end
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        beats++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_beat: actual=%0h expected=none", out_data);
        end else begin
          logic [15:0] want;
          want = exp_q.pop_front();
          total--;
          check_output("beat_data", out_data, want);
        end
      end
    end
    held_prev = check_en && out_valid && !out_ready && !rst_rd && !flush;
    held_data = out_data;
  end

  int pops_w = 0;
  bit check_w = 1'b0;
  bit prev_rinc_w = 1'b0;

  always begin
    @(negedge clk);
    if (check_w) begin
      check_output("wrap_rd_count", rd_count_w, pops_w[3:0]);
      if (rinc_w) check_output("wrap_gap2", prev_rinc_w, 0);
      if (out_valid_w) check_output("wrap_beat", out_data_w, 16'h5A5A);
      if (rinc_w) pops_w++;
      prev_rinc_w = rinc_w;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [7:0] w);
    fifo_q.push_back(w);
  endtask

  task automatic apply_reset();
    rst_rd = 1'b1;
    flush  = 1'b0;
    step(2);
    rst_rd = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int limit);
    int k = 0;
    while (pops < n && k < limit) begin
      step(1);
      k++;
    end
    check_output("pops_reached", pops >= n, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b0;
    int v0;
    int k;

    // T1: reset held with data waiting in the FIFO
    apply_stimulus(8'hA1);
    apply_stimulus(8'hB2);
    step(2);
    check_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_output("t1_rinc", rinc, 0);
      check_output("t1_out_valid", out_valid, 0);
      check_output("t1_out_data", out_data, 0);
      check_output("t1_rd_count", rd_count, 0);
      step(1);
    end

    // T2: simple pack with exact pop spacing
    out_ready = 1'b1;
    b0 = beats;
    v0 = valid_cycles;
    rst_rd = 1'b0;
    wait_pops(2, 40);
    step(3);
    if (pop_cyc.size() >= 2) check_output("t2_spacing", pop_cyc[1] - pop_cyc[0], 6);
    else check_output("t2_pop_times", pop_cyc.size(), 2);
    check_output("t2_beats", beats - b0, 1);
    check_output("t2_valid_cycles", valid_cycles - v0, 1);
    check_output("t2_rd_count", rd_count, 2);

    // T3: backpressure holds the first beat, no third pop meanwhile
    apply_reset();
    out_ready = 1'b0;
    b0 = beats;
    for (int i = 1; i <= 4; i++) apply_stimulus(8'(i));
    step(20);
    check_output("t3_pops_held", pops, 2);
    check_output("t3_valid_held", out_valid, 1);
    check_output("t3_data_held", out_data, 16'h0201);
    out_ready = 1'b1;
    wait_pops(4, 60);
    step(3);
    check_output("t3_beats", beats - b0, 2);
    check_output("t3_rd_count", rd_count, 4);

    // T4: FIFO runs dry after one word
    apply_reset();
    out_ready = 1'b1;
    b0 = beats;
    apply_stimulus(8'h10);
    wait_pops(1, 20);
    v0 = valid_cycles;
    step(10);
    check_output("t4_no_valid", valid_cycles - v0, 0);
    check_output("t4_pops_idle", pops, 1);
    apply_stimulus(8'h20);
    wait_pops(2, 30);
    step(10);
    check_output("t4_beats", beats - b0, 1);
    check_output("t4_no_extra_pop", rd_count, 2);

    // T5: flush drops the lone word but keeps its count
    apply_reset();
    out_ready = 1'b1;
    b0 = beats;
    apply_stimulus(8'h55);
    wait_pops(1, 20);
    step(1);
    flush = 1'b1;
    check_output("t5_rinc_in_flush", rinc, 0);
    step(1);
    flush = 1'b0;
    apply_stimulus(8'h66);
    apply_stimulus(8'h77);
    wait_pops(3, 40);
    step(3);
    check_output("t5_beats", beats - b0, 1);
    check_output("t5_rd_count", rd_count, 3);

    // T6: reset during capture of the second word
    apply_reset();
    out_ready = 1'b1;
    b0 = beats;
    apply_stimulus(8'h31);
    apply_stimulus(8'h32);
    wait_pops(2, 30);
    rst_rd = 1'b1;
    step(1);
    check_output("t6_out_valid", out_valid, 0);
    check_output("t6_out_data", out_data, 0);
    check_output("t6_rd_count", rd_count, 0);
    check_output("t6_rinc", rinc, 0);
    rst_rd = 1'b0;
    apply_stimulus(8'h41);
    apply_stimulus(8'h42);
    wait_pops(2, 30);
    step(3);
    check_output("t6_beats", beats - b0, 1);
    check_output("t6_rd_count_after", rd_count, 2);

    // Random traffic with occasional flush and reset
    apply_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 16) apply_stimulus(8'($urandom_range(0, 255)));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 79) == 0);
      rst_rd    = ($urandom_range(0, 299) == 0);
      step(1);
    end
    flush     = 1'b0;
    rst_rd    = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || out_valid) && k < 400) begin
      step(1);
      k++;
    end
    check_output("rand_drained", exp_q.size(), 0);

    // T7: counter wrap on the narrow instance
    check_w = 1'b1;
    rst_w   = 1'b0;
    k = 0;
    while (pops_w < 16 && k < 100) begin
      step(1);
      k++;
    end
    check_output("t7_pops", pops_w, 16);
    check_output("t7_wrap_zero", rd_count_w, 0);
    step(6);
    check_w = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
